// File: rtl/box_motion.sv
// box_motion: per-frame position engine for the player square.
// Samples tilt and buttons at screenEnd and publishes a clamped top-left coordinate.
module box_motion #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int BOX_SIZE   = 50,
  parameter int DEAD_ZONE  = 16,
  parameter int STEP_SHIFT = 4,
  parameter int MAX_STEP   = 8
) (
  input  logic              clk_25mHz,
  input  logic              reset,
  input  logic              screenEnd,
  input  logic signed [8:0] accel_x,
  input  logic signed [8:0] accel_y,
  input  logic              BTNU,
  input  logic              BTND,
  input  logic              BTNL,
  input  logic              BTNR,
  output logic [9:0]        tl_x,
  output logic [9:0]        tl_y,
  output logic              pos_valid,
  output logic [3:0]        at_edge
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAMPLE  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] APPLY   = 2'd3;

  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - BOX_SIZE);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BOX_SIZE);
  localparam logic [9:0] X_CTR = 10'((SCREEN_W - BOX_SIZE) / 2);
  localparam logic [9:0] Y_CTR = 10'((SCREEN_H - BOX_SIZE) / 2);
  localparam logic signed [8:0] DZ = 9'(DEAD_ZONE);
  localparam logic signed [8:0] MS = 9'(MAX_STEP);

  logic [1:0] state_q, state_d;
  // button bundles are ordered {U, D, L, R}
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] btn_q;
  logic signed [8:0] ax_q, ay_q;
  logic signed [4:0] dx_q, dx_d;
  logic signed [4:0] dy_q, dy_d;
  logic rc_q, rc_d;
  logic [9:0] tl_x_q, tl_x_d;
  logic [9:0] tl_y_q, tl_y_d;
  logic [3:0] edge_q, edge_d;
  logic pv_q;

  function automatic logic signed [4:0] tilt_step(
    input logic signed [8:0] a
  );
    logic signed [8:0] s;
    s = a >>> STEP_SHIFT;
    if (a < DZ && a > -DZ)
      tilt_step = '0;
    else if (s > MS)
      tilt_step = 5'(MS);
    else if (s < -MS)
      tilt_step = 5'(-MS);
    else
      tilt_step = 5'(s);
  endfunction

  function automatic logic signed [4:0] btn_term(
    input logic pos,
    input logic neg
  );
    btn_term = '0;
    unique case (1'b1)
      (pos & ~neg): btn_term = 5'sd1;
      (neg & ~pos): btn_term = -5'sd1;
      default:      btn_term = '0;
    endcase
  endfunction

  function automatic logic signed [11:0] add_step(
    input logic [9:0]        p,
    input logic signed [4:0] d
  );
    add_step = $signed({2'b00, p} + {{7{d[4]}}, d});
  endfunction

  function automatic logic [9:0] clamp(
    input logic signed [11:0] v,
    input logic signed [11:0] hi
  );
    if (v < 12'sd0)
      clamp = '0;
    else if (v > hi)
      clamp = hi[9:0];
    else
      clamp = v[9:0];
  endfunction

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    rc_d    = rc_q;
    tl_x_d  = tl_x_q;
    tl_y_d  = tl_y_q;
    edge_d  = edge_q;
    unique case (state_q)
      IDLE: begin
        if (screenEnd)
          state_d = SAMPLE;
      end
      SAMPLE: state_d = COMPUTE;
      COMPUTE: begin
        state_d = APPLY;
        dx_d = tilt_step(ay_q) + btn_term(btn_q[0], btn_q[1]);
        dy_d = tilt_step(ax_q) + btn_term(btn_q[2], btn_q[3]);
        rc_d = btn_q[3] & btn_q[2];
      end
      APPLY: begin
        state_d = IDLE;
        if (rc_q) begin
          tl_x_d = X_CTR;
          tl_y_d = Y_CTR;
        end else begin
          tl_x_d = clamp(add_step(tl_x_q, dx_q), X_MAX);
          tl_y_d = clamp(add_step(tl_y_q, dy_q), Y_MAX);
        end
        edge_d = {tl_x_d == 10'd0, tl_x_d == X_MAX[9:0],
                  tl_y_d == 10'd0, tl_y_d == Y_MAX[9:0]};
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      rc_q    <= 1'b0;
      tl_x_q  <= X_CTR;
      tl_y_q  <= Y_CTR;
      edge_q  <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= {BTNU, BTND, BTNL, BTNR};
      sync2_q <= sync1_q;
      if (state_q == SAMPLE) begin
        btn_q <= sync2_q;
        ax_q  <= accel_x;
        ay_q  <= accel_y;
      end
      dx_q   <= dx_d;
      dy_q   <= dy_d;
      rc_q   <= rc_d;
      tl_x_q <= tl_x_d;
      tl_y_q <= tl_y_d;
      edge_q <= edge_d;
      pv_q   <= (state_q == APPLY);
    end
  end

  assign tl_x      = tl_x_q;
  assign tl_y      = tl_y_q;
  assign pos_valid = pv_q;
  assign at_edge   = edge_q;

endmodule

// File: tb/tb_box_motion.sv
// tb_box_motion: table vectors, corner sequences and a randomized
// run against an arithmetic model of the box position.
module tb_box_motion;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic screenEnd = 1'b0;
  logic signed [8:0] accel_x = '0;
  logic signed [8:0] accel_y = '0;
  logic BTNU = 0, BTND = 0, BTNL = 0, BTNR = 0;
  logic [9:0] tl_x, tl_y;
  logic pos_valid;
  logic [3:0] at_edge;

  int total = 0;
  int bad = 0;
  int mx, my;

  always #20 clk = ~clk;

  box_motion dut (
    .clk_25mHz(clk),
    .reset(reset),
    .screenEnd(screenEnd),
    .accel_x(accel_x),
    .accel_y(accel_y),
    .BTNU(BTNU),
    .BTND(BTND),
    .BTNL(BTNL),
    .BTNR(BTNR),
    .tl_x(tl_x),
    .tl_y(tl_y),
    .pos_valid(pos_valid),
    .at_edge(at_edge)
  );

  typedef struct {
    bit         rst;
    int         rep;
    int         ax;
    int         ay;
    logic [3:0] btn;
    int         ex;
    int         ey;
    logic [3:0] ee;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    screenEnd = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(tl_x), 295);
    chk("rst_y", int'(tl_y), 215);
    chk("rst_pv", int'(pos_valid), 0);
    chk("rst_edge", int'(at_edge), 0);
    reset = 1'b1;
    @(negedge clk);
    mx = 295;
    my = 215;
  endtask

  task automatic set_in(input int ax, input int ay, input logic [3:0] b);
    accel_x = 9'(ax);
    accel_y = 9'(ay);
    {BTNU, BTND, BTNL, BTNR} = b;
  endtask

  task automatic frame(input int ax, input int ay, input logic [3:0] b);
    int lat;
    @(negedge clk);
    set_in(ax, ay, b);
    repeat (4) @(negedge clk);
    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    lat = 0;
    while (!pos_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    @(negedge clk);
    chk("pv_width", int'(pos_valid), 0);
  endtask

  function automatic int tilt(input int a);
    int q;
    if (a > -16 && a < 16) return 0;
    q = a / 16;
    if (a < 0 && (a % 16) != 0) q = q - 1;
    if (q > 8) q = 8;
    if (q < -8) q = -8;
    return q;
  endfunction

  function automatic int lim(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model(input int ax, input int ay, input logic [3:0] b);
    if (b[3] && b[2]) begin
      mx = 295;
      my = 215;
    end else begin
      mx = lim(mx + tilt(ay) + int'(b[0]) - int'(b[1]), 590);
      my = lim(my + tilt(ax) + int'(b[2]) - int'(b[3]), 430);
    end
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b1, 1, 0, 64, 4'b0000, 299, 215, 4'b0000};
    tbl[1]  = '{1'b1, 1, 0, -200, 4'b0000, 287, 215, 4'b0000};
    tbl[2]  = '{1'b1, 10, 15, 0, 4'b0000, 295, 215, 4'b0000};
    tbl[3]  = '{1'b0, 1, 16, 0, 4'b0000, 295, 216, 4'b0000};
    tbl[4]  = '{1'b1, 41, 0, 127, 4'b0000, 582, 215, 4'b0000};
    tbl[5]  = '{1'b0, 1, 0, 96, 4'b0000, 588, 215, 4'b0000};
    tbl[6]  = '{1'b0, 1, 0, 127, 4'b0000, 590, 215, 4'b0100};
    tbl[7]  = '{1'b0, 1, 0, 127, 4'b0000, 590, 215, 4'b0100};
    tbl[8]  = '{1'b0, 24, -128, 0, 4'b1000, 590, 0, 4'b0110};
    tbl[9]  = '{1'b0, 1, 0, 0, 4'b0011, 590, 0, 4'b0110};
    tbl[10] = '{1'b0, 1, 0, 127, 4'b1100, 295, 215, 4'b0000};
    tbl[11] = '{1'b1, 37, 127, -128, 4'b0000, 0, 430, 4'b1001};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      for (int r = 0; r < tbl[i].rep; r++) begin
        frame(tbl[i].ax, tbl[i].ay, tbl[i].btn);
        if (i == 2) chk("deadzone_y", int'(tl_y), 215);
      end
      chk($sformatf("vec%0d_x", i), int'(tl_x), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(tl_y), tbl[i].ey);
      chk($sformatf("vec%0d_edge", i), int'(at_edge), int'(tbl[i].ee));
    end

    // screenEnd held through SAMPLE and COMPUTE: one update only
    do_reset();
    set_in(0, 64, 4'b0000);
    repeat (4) @(negedge clk);
    screenEnd = 1'b1;
    repeat (3) @(negedge clk);
    screenEnd = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      n += int'(pos_valid);
    end
    chk("repulse_cnt", n, 1);
    chk("repulse_x", int'(tl_x), 299);

    // reset in the middle of a sequence
    do_reset();
    set_in(0, 64, 4'b0000);
    repeat (4) @(negedge clk);
    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n += int'(pos_valid);
    end
    chk("midrst_x", int'(tl_x), 295);
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n += int'(pos_valid);
    end
    chk("midrst_pv", n, 0);
    chk("midrst_x2", int'(tl_x), 295);
    chk("midrst_y2", int'(tl_y), 215);

    // randomized frames against the model
    do_reset();
    for (int k = 0; k < 200; k++) begin
      int ax, ay;
      logic [3:0] b;
      int e;
      ax = int'($urandom_range(0, 511)) - 256;
      ay = int'($urandom_range(0, 511)) - 256;
      if ($urandom_range(0, 2) == 0) ax = int'($urandom_range(0, 40)) - 20;
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) b[3] = 1'b0;
      frame(ax, ay, b);
      model(ax, ay, b);
      e = (mx == 0 ? 8 : 0) + (mx == 590 ? 4 : 0)
        + (my == 0 ? 2 : 0) + (my == 430 ? 1 : 0);
      chk("rand_x", int'(tl_x), mx);
      chk("rand_y", int'(tl_y), my);
      chk("rand_edge", int'(at_edge), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
